// File: rtl/signed_sat_accumulator.sv
// Frame accumulator for the 4-bit saturated-sum path.
// It sums signed samples with saturation and returns the frame total over a valid/ready handshake.
module signed_sat_accumulator #(
  parameter int IN_W  = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic [CNT_W-1:0] out_count
);

  typedef enum logic {ACC, OUT} state_t;

  localparam logic [ACC_W-1:0] MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t state, state_nx;

  logic [ACC_W-1:0] acc, ext, sum, sum_sat;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             sat_flag, ovf, beat;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == OUT);
  assign beat      = in_valid && in_ready;

  assign ext = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign sum = acc + ext;

  // Overflow only when both operands share a sign and the result flips it
  assign ovf = (acc[ACC_W-1] == ext[ACC_W-1]) &&
               (sum[ACC_W-1] != acc[ACC_W-1]);

  assign sum_sat = ovf ? (acc[ACC_W-1] ? MIN : MAX) : sum;
  assign cnt_nx  = (&cnt) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ACC: if (beat && in_last) state_nx = OUT;
      OUT: if (out_ready)       state_nx = ACC;
      default:                  state_nx = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sat_flag  <= 1'b0;
      cnt       <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else if (beat) begin
      if (in_last) begin
        out_data  <= sum_sat;
        out_sat   <= sat_flag | ovf;
        out_count <= cnt_nx;
        acc       <= '0;
        sat_flag  <= 1'b0;
        cnt       <= '0;
      end else begin
        acc      <= sum_sat;
        sat_flag <= sat_flag | ovf;
        cnt      <= cnt_nx;
      end
    end
  end

endmodule

// File: tb/tb_signed_sat_accumulator.sv
// Directed bench for signed_sat_accumulator.
// Expected values are hand computed.
module tb_signed_sat_accumulator;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;
  logic [7:0] out_count;

  int total = 0;
  int bad   = 0;
  int waits;

  signed_sat_accumulator #(.IN_W(4), .ACC_W(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat edge.
  task automatic push(input logic [3:0] d, input logic l,
                      output int w);
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("ready_timeout", in_ready, 1);
    @(negedge clk);
  endtask

  task automatic expect_result(input string tag,
                               input logic [7:0] d,
                               input logic s,
                               input logic [7:0] c);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_sat"}, out_sat, s);
    check({tag, "_count"}, out_count, c);
    check({tag, "_inrdy"}, in_ready, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_sat", out_sat, 0);
    check("rst_count", out_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_inrdy", in_ready, 1);

    // 1 + 2 + 3
    push(4'd1, 1'b0, waits);
    push(4'd2, 1'b0, waits);
    push(4'd3, 1'b1, waits);
    in_valid = 1'b0;
    expect_result("f123", 8'd6, 1'b0, 8'd3);
    @(negedge clk);
    check("f123_back", in_ready, 1);
    check("f123_ovdone", out_valid, 0);

    // 19 x +7 clamps at 127
    for (int i = 0; i < 18; i++) push(4'd7, 1'b0, waits);
    push(4'd7, 1'b1, waits);
    in_valid = 1'b0;
    expect_result("pos", 8'd127, 1'b1, 8'd19);
    @(negedge clk);

    // 17 x -8 clamps at -128, then +28 resumes from the rail
    for (int i = 0; i < 17; i++) push(4'h8, 1'b0, waits);
    for (int i = 0; i < 3; i++) push(4'd7, 1'b0, waits);
    push(4'd7, 1'b1, waits);
    in_valid = 1'b0;
    expect_result("neg", 8'h9C, 1'b1, 8'd21);
    @(negedge clk);

    // Backpressure holds the result and blocks input
    out_ready = 1'b0;
    push(4'hF, 1'b1, waits);
    in_valid = 1'b1;
    in_data  = 4'd5;
    in_last  = 1'b0;
    expect_result("m1", 8'hFF, 1'b0, 8'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_result("hold", 8'hFF, 1'b0, 8'd1);
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    push(4'd5, 1'b1, waits);
    in_valid = 1'b0;
    expect_result("five", 8'd5, 1'b0, 8'd1);
    @(negedge clk);

    // Mid-frame async reset discards the partial frame
    push(4'd1, 1'b0, waits);
    push(4'd2, 1'b0, waits);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_data", out_data, 0);
    check("mrst_count", out_count, 0);
    check("mrst_inrdy", in_ready, 1);
    #1 rst_n = 1'b1;
    @(negedge clk);
    push(4'd4, 1'b1, waits);
    in_valid = 1'b0;
    expect_result("after_rst", 8'd4, 1'b0, 8'd1);
    @(negedge clk);

    // Back-to-back frames with continuous valid
    push(4'd7, 1'b0, waits);
    push(4'd7, 1'b1, waits);
    expect_result("b2b_a", 8'd14, 1'b0, 8'd2);
    push(4'h8, 1'b0, waits);
    check("b2b_bubble", waits, 1);
    push(4'h8, 1'b1, waits);
    in_valid = 1'b0;
    expect_result("b2b_b", 8'hF0, 1'b0, 8'd2);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/signed_sat_accumulator.md
Name: signed_sat_accumulator

Overview:
- Streaming downstream stage for the 4-bit signed saturating adder path.
- Consumes a frame of signed samples through a valid/ready handshake and accumulates them with saturation into a wider signed register.
- Delivers the frame total, a sticky saturation flag and a sample count on a registered valid/ready output.
- Sits between the per-sample saturated-sum producer and the frame-level consumer.

Parameters:
- IN_W, 4, width of signed input sample (two's complement).
- ACC_W, 8, width of signed accumulator and result; ACC_W > IN_W.
- CNT_W, 8, width of per-frame sample counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present.
- in_ready  output  1  block accepts sample this cycle.
- in_data  input  IN_W  signed sample.
- in_last  input  1  sample is the final one of the frame; qualified by in_valid.
- out_valid  output  1  frame result present.
- out_ready  input  1  consumer accepts result.
- out_data  output  ACC_W  signed saturated frame total.
- out_sat  output  1  saturation occurred at least once in the frame.
- out_count  output  CNT_W  samples accepted in the frame, saturating at all-ones.

Behaviour:
- Clock and reset (already decided): one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - state = ACC.
  - Accumulator, sticky flag and counter = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, out_count = 0, in_ready = 1 after reset release.
- States: ACC, OUT.
- ACC state:
  - in_ready = 1, out_valid = 0.
  - Input beat = in_valid && in_ready.
  - On each beat: acc <= sat(acc + sign_extend(in_data)). sat_flag <= sat_flag | clipped. cnt <= (cnt == all-ones) ? cnt : cnt + 1.
- Saturation rule:
  - Overflow occurs when both operands have the same sign and the raw ACC_W-bit result's sign differs.
  - Positive overflow clamps to 2^(ACC_W-1)-1 (127).
  - Negative overflow clamps to -2^(ACC_W-1) (-128).
  - No overflow is possible when the operand signs differ.
  - Accumulation continues from the clamped value; there is no latching at the rail.
- Beat with in_last = 1:
  - The last sample is included.
  - out_data, out_sat and out_count load the updated values (including this beat).
  - State moves to OUT.
  - Internal acc, sat_flag and cnt clear to 0 in the same edge.
  - out_valid = 1 on the cycle after the last beat (latency 1).
- OUT state:
  - in_ready = 0; in_valid and in_data are ignored and no sample is consumed.
  - out_valid = 1.
  - out_data, out_sat and out_count are held stable while out_valid && !out_ready.
  - On out_valid && out_ready: return to ACC. in_ready = 1 on the next cycle, so there is one bubble per frame.
  - out_* register values may persist after the handshake; they are valid only when out_valid = 1.
- Single-sample frame (in_last on the first beat) is legal; out_count = 1.
- in_valid = 0 in ACC: state is held and nothing changes.
- rst_n asserted mid-frame or mid-OUT: all state clears immediately. The partial frame is discarded and any pending result is dropped.
- in_ready depends only on state, never on in_valid (no combinational loop). out_valid is registered.

Test Plan:
- Frame 1, 2, 3 (last on 3), out_ready = 1 → one cycle after the last beat: out_valid = 1, out_data = 6, out_sat = 0, out_count = 3.
- 19 samples of +7, last on the 19th → out_data = 127 (raw 133), out_sat = 1, out_count = 19.
- 17 samples of -8, then 4 samples of +7 (last) → out_data = -128 + 28 = -100 (8'h9C), out_sat = 1, out_count = 21. This checks accumulation resumes from the rail.
- Frame with only -1 (last) → out_data = 8'hFF, out_sat = 0, out_count = 1. Hold out_ready = 0 for 3 cycles while driving in_valid = 1 with data 5 → outputs stable, in_ready = 0, sample 5 not counted. Next frame 5 (last) → out_data = 5, out_count = 1.
- Accept 1, 2 (no last), pulse rst_n low for 1 cycle between edges → all outputs 0 immediately. Then frame 4 (last) → out_data = 4, out_count = 1, out_sat = 0.
- Back-to-back frames 7, 7 (last) then -8, -8 (last) with continuous in_valid and out_ready = 1 → results 14 then -16, out_sat = 0 both. Exactly one idle cycle (in_ready = 0) between frames.
